// File: rtl/sram_writeback_pkg.sv
// Shared widths and types for the SRAM write-back stage.
package sram_writeback_pkg;

  localparam int SRAM_DATA_W = 64;
  localparam int SRAM_ADDR_W = 13;
  localparam int SRAM_LEN_W  = 16;

  typedef logic [1:0] wb_state_t;

endpackage

// File: rtl/sram_writeback_if.sv
// SRAM write port: request, address and data out; grant back.
// Handshake: a write completes in the cycle sram_wr_en_o && sram_gnt_i;
// until then sram_wr_en_o, sram_addr_o and sram_wdata_o hold steady.
interface sram_writeback_if
  import sram_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_W,
  parameter int ADDR_WIDTH = SRAM_ADDR_W
);
  logic                  sram_wr_en_o;
  logic [ADDR_WIDTH-1:0] sram_addr_o;
  logic [DATA_WIDTH-1:0] sram_wdata_o;
  logic                  sram_gnt_i;

  modport master (
    output sram_wr_en_o,
    output sram_addr_o,
    output sram_wdata_o,
    input  sram_gnt_i
  );

  modport slave (
    input  sram_wr_en_o,
    input  sram_addr_o,
    input  sram_wdata_o,
    output sram_gnt_i
  );
endinterface

// File: rtl/sram_writeback_sync_fifo.sv
// Small synchronous FIFO with combinational head; push while full is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sram_writeback.sv
// Buffers repacker words and writes them to SRAM at consecutive addresses
// from a programmed base; pulses done after the programmed word count.
module sram_writeback
  import sram_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_W,
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int LEN_WIDTH  = SRAM_LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  num_words_i,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_i,
  sram_writeback_if.master      sram,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output wb_state_t             state_dbg
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  wb_state_t             state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  num_words_q;
  logic [LEN_WIDTH-1:0]  accepted;
  logic [LEN_WIDTH-1:0]  written;
  logic [LEN_WIDTH-1:0]  written_nxt;
  logic                  overflow_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  wr_en;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  start_acc;

  // The request side depends only on registered state and FIFO contents.
  assign wr_en       = (state == ST_RUN) && !fifo_empty;
  assign pop         = wr_en && sram.sram_gnt_i;
  assign push        = in_valid && (state == ST_RUN) && (accepted < num_words_q)
                       && (!fifo_full || pop);
  assign drop        = in_valid && !push;
  assign start_acc   = (state == ST_IDLE) && start_i;
  assign written_nxt = written + LEN_WIDTH'(pop);

  assign sram.sram_wr_en_o = wr_en;
  assign sram.sram_addr_o  = addr_q;
  assign sram.sram_wdata_o = fifo_head;
  assign busy_o            = (state != ST_IDLE);
  assign done_o            = (state == ST_DONE);
  assign overflow_o        = overflow_q;
  assign state_dbg         = state;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (data_i),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      num_words_q <= '0;
      accepted    <= '0;
      written     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state       <= ST_RUN;
            addr_q      <= base_addr_i;
            num_words_q <= num_words_i;
            accepted    <= '0;
            written     <= '0;
          end
        end
        ST_RUN: begin
          if (push) accepted <= accepted + LEN_WIDTH'(1);
          if (pop) begin
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            written <= written_nxt;
          end
          // Looking at the post-grant count puts DONE right after the last grant.
          if (written_nxt == num_words_q) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (start_acc)  overflow_q <= drop;
      else if (drop)  overflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_writeback.sv
// Directed bench for sram_writeback: per-cycle vector table plus
// hand-written overflow, full push/pop and mid-transfer reset sequences.
module tb_sram_writeback;
  import sram_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [12:0] base_addr_i;
  logic [15:0] num_words_i;
  logic        in_valid;
  logic [63:0] data_i;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;
  wb_state_t   state_dbg;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic done_seen = 1'b0;
  logic sb_en = 1'b0;
  logic [76:0] exp_q[$];

  sram_writeback_if bus ();

  sram_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_words_i (num_words_i),
    .in_valid    (in_valid),
    .data_i      (data_i),
    .sram        (bus.master),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o),
    .state_dbg   (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard: every granted write must match the head of exp_q
  always @(negedge clk) begin
    if (sb_en) begin
      if (done_o) done_seen = 1'b1;
      if (bus.sram_wr_en_o && bus.sram_gnt_i) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: got addr %h data %h expected no write",
                   bus.sram_addr_o, bus.sram_wdata_o);
        end else begin
          logic [76:0] e;
          e = exp_q.pop_front();
          if ({bus.sram_addr_o, bus.sram_wdata_o} !== e) begin
            errors++;
            $display("FAIL sb_write: got %h:%h expected %h:%h",
                     bus.sram_addr_o, bus.sram_wdata_o, e[76:64], e[63:0]);
          end
        end
      end
    end
  end

  typedef struct {
    logic        start;
    logic [12:0] base;
    logic [15:0] num;
    logic        iv;
    logic [63:0] data;
    logic        exp_wr;
    logic [12:0] exp_addr;
    logic [63:0] exp_data;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_ovf;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [12:0] b, input logic [15:0] n,
                              input logic iv, input logic [63:0] d, input logic ew,
                              input logic [12:0] ea, input logic [63:0] ed,
                              input logic eb, input logic edn, input logic eo);
    vec_t v;
    v.start = st; v.base = b; v.num = n; v.iv = iv; v.data = d;
    v.exp_wr = ew; v.exp_addr = ea; v.exp_data = ed;
    v.exp_busy = eb; v.exp_done = edn; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic drive_idle();
    start_i = 1'b0; in_valid = 1'b0; data_i = '0;
  endtask

  task automatic push_word(input logic [63:0] d, input logic [12:0] a, input logic expect_write);
    in_valid = 1'b1;
    data_i   = d;
    if (expect_write) exp_q.push_back({a, d});
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done_o && n < 20) begin
      step();
      n++;
    end
    chk(nm, {63'd0, done_o}, 64'd1);
  endtask

  localparam logic [63:0] WA = 64'hA0A0_0000_0000_000A;
  localparam logic [63:0] WB = 64'hB0B0_0000_0000_000B;
  localparam logic [63:0] WC = 64'hC0C0_0000_0000_000C;
  localparam logic [63:0] WD = 64'hD0D0_1111_2222_000D;
  localparam logic [63:0] WE = 64'hE0E0_3333_4444_000E;
  localparam logic [63:0] WF = 64'hF0F0_5555_6666_000F;
  localparam logic [63:0] WX = 64'h1234_5678_9ABC_DEF0;

  vec_t vecs[21];

  initial begin
    rst = 1'b1;
    base_addr_i = '0;
    num_words_i = '0;
    bus.sram_gnt_i = 1'b1;
    drive_idle();
    repeat (3) step();
    rst = 1'b0;

    chk("reset_wr_en", {63'd0, bus.sram_wr_en_o}, 64'd0);
    chk("reset_addr",  {51'd0, bus.sram_addr_o}, 64'd0);
    chk("reset_wdata", bus.sram_wdata_o, 64'd0);
    chk("reset_busy",  {63'd0, busy_o}, 64'd0);
    chk("reset_done",  {63'd0, done_o}, 64'd0);
    chk("reset_ovf",   {63'd0, overflow_o}, 64'd0);
    chk("reset_state", {62'd0, state_dbg}, 64'd0);

    //              st  base     num iv  data ew  addr     wdata bsy dn ovf
    vecs[0]  = mk(1, 13'h100,  3, 0, 0,  0, 0,       0,  0, 0, 0);
    vecs[1]  = mk(0, 0,        0, 1, WA, 0, 0,       0,  1, 0, 0);
    vecs[2]  = mk(0, 0,        0, 1, WB, 1, 13'h100, WA, 1, 0, 0);
    vecs[3]  = mk(0, 0,        0, 1, WC, 1, 13'h101, WB, 1, 0, 0);
    vecs[4]  = mk(0, 0,        0, 0, 0,  1, 13'h102, WC, 1, 0, 0);
    vecs[5]  = mk(0, 0,        0, 0, 0,  0, 0,       0,  1, 1, 0);
    vecs[6]  = mk(1, 13'h1FFF, 2, 0, 0,  0, 0,       0,  0, 0, 0);
    vecs[7]  = mk(0, 0,        0, 1, WD, 0, 0,       0,  1, 0, 0);
    vecs[8]  = mk(0, 0,        0, 1, WE, 1, 13'h1FFF,WD, 1, 0, 0);
    vecs[9]  = mk(0, 0,        0, 0, 0,  1, 13'h000, WE, 1, 0, 0);
    vecs[10] = mk(0, 0,        0, 0, 0,  0, 0,       0,  1, 1, 0);
    vecs[11] = mk(1, 13'h000,  0, 0, 0,  0, 0,       0,  0, 0, 0);
    vecs[12] = mk(0, 0,        0, 0, 0,  0, 0,       0,  1, 0, 0);
    vecs[13] = mk(0, 0,        0, 0, 0,  0, 0,       0,  1, 1, 0);
    vecs[14] = mk(0, 0,        0, 1, WX, 0, 0,       0,  0, 0, 0);
    vecs[15] = mk(0, 0,        0, 0, 0,  0, 0,       0,  0, 0, 1);
    vecs[16] = mk(1, 13'h010,  1, 0, 0,  0, 0,       0,  0, 0, 1);
    vecs[17] = mk(0, 0,        0, 1, WF, 0, 0,       0,  1, 0, 0);
    vecs[18] = mk(0, 0,        0, 0, 0,  1, 13'h010, WF, 1, 0, 0);
    vecs[19] = mk(0, 0,        0, 0, 0,  0, 0,       0,  1, 1, 0);
    vecs[20] = mk(0, 0,        0, 0, 0,  0, 0,       0,  0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      start_i     = vecs[i].start;
      base_addr_i = vecs[i].base;
      num_words_i = vecs[i].num;
      in_valid    = vecs[i].iv;
      data_i      = vecs[i].data;
      chk($sformatf("vec%0d_wr_en", i), {63'd0, bus.sram_wr_en_o}, {63'd0, vecs[i].exp_wr});
      chk($sformatf("vec%0d_busy", i),  {63'd0, busy_o}, {63'd0, vecs[i].exp_busy});
      chk($sformatf("vec%0d_done", i),  {63'd0, done_o}, {63'd0, vecs[i].exp_done});
      chk($sformatf("vec%0d_ovf", i),   {63'd0, overflow_o}, {63'd0, vecs[i].exp_ovf});
      if (vecs[i].exp_wr) begin
        chk($sformatf("vec%0d_addr", i), {51'd0, bus.sram_addr_o}, {51'd0, vecs[i].exp_addr});
        chk($sformatf("vec%0d_data", i), bus.sram_wdata_o, vecs[i].exp_data);
      end
      step();
    end
    drive_idle();

    // Overflow: grant held low while six words arrive into a 4-deep FIFO.
    sb_en = 1'b1;
    wr_cnt = 0;
    done_seen = 1'b0;
    bus.sram_gnt_i = 1'b0;
    start_i = 1'b1; base_addr_i = 13'h200; num_words_i = 16'd6;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_word(64'h5000 + 64'(i), 13'h200 + 13'(i), i < 4);
      step();
    end
    drive_idle();
    repeat (4) step();
    chk("ovf_sticky", {63'd0, overflow_o}, 64'd1);
    chk("ovf_wr_pending", {63'd0, bus.sram_wr_en_o}, 64'd1);
    chk("ovf_addr_held", {51'd0, bus.sram_addr_o}, 64'h200);
    bus.sram_gnt_i = 1'b1;
    repeat (6) step();
    chk("ovf_four_writes", 64'(wr_cnt), 64'd4);
    chk("ovf_no_done_yet", {63'd0, done_seen}, 64'd0);
    chk("ovf_still_busy", {63'd0, busy_o}, 64'd1);
    chk("ovf_fifo_drained", {63'd0, bus.sram_wr_en_o}, 64'd0);
    push_word(64'h6000, 13'h204, 1'b1);
    step();
    push_word(64'h6001, 13'h205, 1'b1);
    step();
    drive_idle();
    wait_done("ovf_done");
    chk("ovf_total_writes", 64'(wr_cnt), 64'd6);
    chk("ovf_queue_empty", 64'(exp_q.size()), 64'd0);
    step();

    // Full FIFO with simultaneous push and pop.
    wr_cnt = 0;
    bus.sram_gnt_i = 1'b0;
    start_i = 1'b1; base_addr_i = 13'h300; num_words_i = 16'd10;
    step();
    start_i = 1'b0;
    chk("full_ovf_cleared", {63'd0, overflow_o}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      push_word(64'h7000 + 64'(i), 13'h300 + 13'(i), 1'b1);
      step();
    end
    push_word(64'h7004, 13'h304, 1'b1);
    bus.sram_gnt_i = 1'b1;
    step();
    drive_idle();
    repeat (4) step();
    chk("full_writes", 64'(wr_cnt), 64'd5);
    chk("full_no_drop", {63'd0, overflow_o}, 64'd0);
    chk("full_drained", {63'd0, bus.sram_wr_en_o}, 64'd0);
    chk("full_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two words buffered; they must never be written.
    bus.sram_gnt_i = 1'b0;
    push_word(64'hDEAD_0001, 13'h305, 1'b0);
    step();
    push_word(64'hDEAD_0002, 13'h306, 1'b0);
    step();
    drive_idle();
    chk("rst_pre_pending", {63'd0, bus.sram_wr_en_o}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_wr_en", {63'd0, bus.sram_wr_en_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_addr", {51'd0, bus.sram_addr_o}, 64'd0);
    chk("rst_wdata", bus.sram_wdata_o, 64'd0);
    chk("rst_state", {62'd0, state_dbg}, 64'd0);
    wr_cnt = 0;
    bus.sram_gnt_i = 1'b1;
    start_i = 1'b1; base_addr_i = 13'h040; num_words_i = 16'd2;
    step();
    start_i = 1'b0;
    push_word(64'h8888_0001, 13'h040, 1'b1);
    step();
    push_word(64'h8888_0002, 13'h041, 1'b1);
    step();
    drive_idle();
    wait_done("rst_new_done");
    chk("rst_new_writes", 64'(wr_cnt), 64'd2);
    chk("rst_queue_empty", 64'(exp_q.size()), 64'd0);
    step();
    chk("final_idle", {63'd0, busy_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
